nec_cmd_queue: RTL and testbench
================================

# nec_cmd_queue

Downstream consumer of the NEC IR receiver (`ir_rcv`). It takes each 32-bit frame the receiver flags with its one-cycle `ready` pulse and checks the address and command complement bytes. Good frames are tagged as new presses or auto-repeats and queued in a small FIFO for the application logic, which drains it with a valid/ready handshake. Bad frames and frames dropped on overflow are counted.

## Interface
- `FIFO_DEPTH`, 4: queue entries; power of two, ≥2.
- `REPEAT_WINDOW`, 12_000_000: clock cycles (120 ms at 100 MHz). An identical frame arriving inside this window is tagged repeat.
- `CNT_W`, 8: width of the error and drop counters.
- `clk`  in  1  system clock, 100 MHz.
- `rst`  in  1  synchronous, active-low reset.
- `burst`  in  32  frame from `ir_rcv`; valid only while `frame_rdy` is high.
- `frame_rdy`  in  1  one-cycle pulse from `ir_rcv` `ready`.
- `cmd_addr`  out  8  head-entry address.
- `cmd_data`  out  8  head-entry command.
- `cmd_repeat`  out  1  head entry is an auto-repeat.
- `cmd_valid`  out  1  FIFO not empty.
- `cmd_ready`  in  1  consumer accepts the head entry this cycle.
- `err_count`  out  CNT_W  complement-check failures; saturating.
- `drop_count`  out  CNT_W  good frames lost to a full queue; saturating.

## Operation
- Frame layout, LSB-first on air: `burst[7:0]`=addr, `[15:8]`=~addr, `[23:16]`=cmd, `[31:24]`=~cmd.
- Check on the `frame_rdy` cycle. Good means `burst[15:8] == ~burst[7:0]` and `burst[31:24] == ~burst[23:16]`.
- Bad frame: `err_count`+1, saturating at all-ones. No push. Repeat state is unchanged.
- Good frame: `rep = last_vld && {addr,cmd}=={last_addr,last_cmd} && win_cnt!=0`.
  - Push `{rep,addr,cmd}`.
  - Load `last_*`, set `last_vld`, reload `win_cnt` to `REPEAT_WINDOW-1`.
  - These updates happen even when the push is dropped.
- `win_cnt` decrements every cycle while non-zero and holds at 0.
- Push accepted if not full, or if full and a pop happens the same cycle. Otherwise the frame is dropped and `drop_count`+1, saturating.
- Pop when `cmd_valid && cmd_ready`. `cmd_ready` while empty has no effect.
- Outputs are show-ahead: `cmd_addr/data/repeat` always show the head entry. When empty they hold the last value and are don't-care.
- Pointers are `$clog2(FIFO_DEPTH)` bits wide and wrap naturally. A separate occupancy count of `$clog2(FIFO_DEPTH)+1` bits gives full/empty.

## Timing
- Reset (`rst`=0 at a clk edge) values:
  - `cmd_valid`=0, `cmd_addr`=0, `cmd_data`=0, `cmd_repeat`=0.
  - `err_count`=0, `drop_count`=0.
  - Pointers and occupancy 0, `last_vld`=0, `win_cnt`=0.
- Reset wins over a same-cycle `frame_rdy` or pop.
- Reset mid-operation discards all queued entries.
- Latency: `frame_rdy` sampled at edge N; `cmd_valid` and data are visible after edge N, i.e. one cycle.
- No empty-queue bypass.
- Push and pop in the same cycle when non-empty: occupancy unchanged, head advances.
- Push and pop in the same cycle when empty: the pop is ignored and the push lands.
- A frame at exactly `win_cnt`==0 is not a repeat. The last repeat-eligible arrival is `REPEAT_WINDOW-1` cycles after the previous good frame.
- A `frame_rdy` on consecutive cycles is legal. Each pulse is processed independently.

## Structure
- Package `nec_pkg`: `NEC_FRAME_W`=32, `NEC_BYTE_W`=8, field-offset constants, and packed struct `nec_cmd_t {logic repeat; logic [7:0] addr; logic [7:0] cmd;}`.
- Sub-module `sync_fifo` (parameters WIDTH, DEPTH; push/pop/full/empty/count, show-ahead) holds the queue.
- The top level holds the complement check, repeat tracker, and counters.

## Test plan
- Good frame addr=0x10, cmd=0xD8 (`burst`=0x27D8EF10), consumer `cmd_ready`=1 → `cmd_valid` for 1 cycle, addr 0x10, data 0xD8, repeat 0.
- Same frame again 50 000 cycles later → repeat=1. Again `REPEAT_WINDOW` cycles after that → repeat=0.
- Corrupt byte 1 (`burst`=0x27D8EE10) → `err_count`=1, `cmd_valid` stays 0. Then 256 bad frames with `CNT_W`=8 → holds at 255.
- `cmd_ready`=0 and 5 distinct good frames → 4 queued, `drop_count`=1. Drain → data in arrival order, then `cmd_valid`=0.
- Queue full, with `frame_rdy` and `cmd_ready` in the same cycle → `drop_count` unchanged, occupancy stays 4, new frame is the tail.
- Reset asserted with 3 entries queued → next cycle `cmd_valid`=0, both counters 0. A following identical frame gets repeat=0.

Source files
------------

// File: rtl/nec_pkg.sv
// Shared NEC frame constants, the queued command record and the frame integrity check.
package nec_pkg;

    localparam int NEC_FRAME_W = 32;
    localparam int NEC_BYTE_W  = 8;

    // Byte offsets inside a received frame (LSB-first on air).
    localparam int ADDR_LSB   = 0;
    localparam int ADDR_N_LSB = 8;
    localparam int CMD_LSB    = 16;
    localparam int CMD_N_LSB  = 24;

    // 'repeat' is a reserved word, so the tag bit is called is_repeat.
    typedef struct packed {
        logic                  is_repeat;
        logic [NEC_BYTE_W-1:0] addr;
        logic [NEC_BYTE_W-1:0] cmd;
    } nec_cmd_t;

    // A frame is good when both the address and command bytes are followed by their complements.
    function automatic logic frame_good(input logic [NEC_FRAME_W-1:0] f);
        return (f[ADDR_N_LSB +: NEC_BYTE_W] == ~f[ADDR_LSB +: NEC_BYTE_W]) &&
               (f[CMD_N_LSB  +: NEC_BYTE_W] == ~f[CMD_LSB  +: NEC_BYTE_W]);
    endfunction

endpackage

// File: rtl/nec_cmd_queue_sync_fifo.sv
// Small show-ahead synchronous FIFO; the head entry is always visible on dout.
module sync_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic [PTR_W:0]   count_next;
    logic [WIDTH-1:0] entries [DEPTH];
    logic             push_en;
    logic             pop_en;

    // A pop on an empty queue is ignored; a push into a full queue only lands if a pop frees a slot.
    assign pop_en  = pop && !empty;
    assign push_en = push && (!full || pop_en);

    assign empty = (count_reg == '0);
    assign full  = (count_reg == (PTR_W+1)'(DEPTH));
    assign count = count_reg;
    assign dout  = entries[rd_ptr_reg];

    // Storage entries are cleared on reset so the head reads zero after reset.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        logic [WIDTH-1:0] entry_reg;

        // Capture the pushed word into the slot addressed by the write pointer.
        always_ff @(posedge clk) begin
            if (!rst) begin
                entry_reg <= '0;
            end else if (push_en && (wr_ptr_reg == PTR_W'(gi))) begin
                entry_reg <= din;
            end
        end

        assign entries[gi] = entry_reg;
    end

    // Occupancy follows the accepted push/pop combination.
    always_comb begin
        count_next = count_reg;
        case ({push_en, pop_en})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    // Pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop_en)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/nec_cmd_queue.sv
// NEC frame checker: validates complements, tags auto-repeats, queues commands, counts errors and drops.
module nec_cmd_queue
    import nec_pkg::*;
#(
    parameter int FIFO_DEPTH    = 4,
    parameter int REPEAT_WINDOW = 12_000_000,
    parameter int CNT_W         = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NEC_FRAME_W-1:0] burst,
    input  logic                   frame_rdy,
    output logic [NEC_BYTE_W-1:0]  cmd_addr,
    output logic [NEC_BYTE_W-1:0]  cmd_data,
    output logic                   cmd_repeat,
    output logic                   cmd_valid,
    input  logic                   cmd_ready,
    output logic [CNT_W-1:0]       err_count,
    output logic [CNT_W-1:0]       drop_count
);

    localparam int                WIN_W      = $clog2(REPEAT_WINDOW + 1);
    localparam logic [WIN_W-1:0]  WIN_RELOAD = WIN_W'(REPEAT_WINDOW - 1);
    localparam int                OCC_W      = $clog2(FIFO_DEPTH) + 1;

    logic [NEC_BYTE_W-1:0] frame_addr;
    logic [NEC_BYTE_W-1:0] frame_cmd;
    logic                  good_frame;
    logic                  bad_frame;
    logic                  rep;
    nec_cmd_t              push_cmd;
    nec_cmd_t              head_cmd;

    logic                  fifo_full;
    logic                  fifo_empty;
    logic [OCC_W-1:0]      fifo_count;
    logic                  pop_en;
    logic                  drop;

    logic                  last_vld_reg;
    logic [NEC_BYTE_W-1:0] last_addr_reg;
    logic [NEC_BYTE_W-1:0] last_cmd_reg;
    logic [WIN_W-1:0]      win_cnt_reg;
    logic [CNT_W-1:0]      err_count_reg;
    logic [CNT_W-1:0]      drop_count_reg;

    assign frame_addr = burst[ADDR_LSB +: NEC_BYTE_W];
    assign frame_cmd  = burst[CMD_LSB  +: NEC_BYTE_W];
    assign good_frame = frame_rdy && frame_good(burst);
    assign bad_frame  = frame_rdy && !frame_good(burst);

    // Identical frame while the window is still open is an auto-repeat; win_cnt==0 means it expired.
    assign rep = last_vld_reg && (frame_addr == last_addr_reg) &&
                 (frame_cmd == last_cmd_reg) && (win_cnt_reg != '0);

    assign push_cmd = '{is_repeat: rep, addr: frame_addr, cmd: frame_cmd};

    // A full queue still accepts the push when the consumer frees the head in the same cycle.
    assign pop_en = cmd_ready && !fifo_empty;
    assign drop   = good_frame && fifo_full && !pop_en;

    sync_fifo #(
        .WIDTH ($bits(nec_cmd_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (good_frame),
        .pop   (cmd_ready),
        .din   (push_cmd),
        .dout  (head_cmd),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign cmd_valid  = (fifo_count != '0);
    assign cmd_addr   = head_cmd.addr;
    assign cmd_data   = head_cmd.cmd;
    assign cmd_repeat = head_cmd.is_repeat;
    assign err_count  = err_count_reg;
    assign drop_count = drop_count_reg;

    // Repeat tracker: every good frame (even one that is dropped) refreshes the reference and window.
    always_ff @(posedge clk) begin
        if (!rst) begin
            last_vld_reg  <= 1'b0;
            last_addr_reg <= '0;
            last_cmd_reg  <= '0;
            win_cnt_reg   <= '0;
        end else if (good_frame) begin
            last_vld_reg  <= 1'b1;
            last_addr_reg <= frame_addr;
            last_cmd_reg  <= frame_cmd;
            win_cnt_reg   <= WIN_RELOAD;
        end else if (win_cnt_reg != '0) begin
            win_cnt_reg   <= win_cnt_reg - 1'b1;
        end
    end

    // Saturating error and drop counters.
    always_ff @(posedge clk) begin
        if (!rst) begin
            err_count_reg  <= '0;
            drop_count_reg <= '0;
        end else begin
            if (bad_frame && (err_count_reg != '1)) err_count_reg  <= err_count_reg + 1'b1;
            if (drop && (drop_count_reg != '1))     drop_count_reg <= drop_count_reg + 1'b1;
        end
    end

endmodule

// File: tb/tb_nec_cmd_queue.sv
// Directed bench for nec_cmd_queue with a shortened repeat window.
module tb_nec_cmd_queue;

    localparam int FIFO_DEPTH    = 4;
    localparam int REPEAT_WINDOW = 1000;
    localparam int CNT_W         = 8;

    logic             clk;
    logic             rst;
    logic [31:0]      burst;
    logic             frame_rdy;
    logic [7:0]       cmd_addr;
    logic [7:0]       cmd_data;
    logic             cmd_repeat;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [CNT_W-1:0] err_count;
    logic [CNT_W-1:0] drop_count;

    int checks   = 0;
    int failures = 0;

    nec_cmd_queue #(
        .FIFO_DEPTH    (FIFO_DEPTH),
        .REPEAT_WINDOW (REPEAT_WINDOW),
        .CNT_W         (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .burst      (burst),
        .frame_rdy  (frame_rdy),
        .cmd_addr   (cmd_addr),
        .cmd_data   (cmd_data),
        .cmd_repeat (cmd_repeat),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .err_count  (err_count),
        .drop_count (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input logic [7:0] a, input logic [7:0] c);
        return {~c, c, ~a, a};
    endfunction

    // Called at a negedge; the frame is sampled at the next posedge, returns at the following negedge.
    task automatic send(input logic [31:0] b);
        burst     = b;
        frame_rdy = 1'b1;
        @(negedge clk);
        frame_rdy = 1'b0;
        $display("frame burst=%08h valid=%0b addr=%02h data=%02h rep=%0b err=%0d drop=%0d",
                 b, cmd_valid, cmd_addr, cmd_data, cmd_repeat, err_count, drop_count);
    endtask

    task automatic test_reset();
        rst = 1'b0; frame_rdy = 1'b0; cmd_ready = 1'b0; burst = '0;
        repeat (3) @(negedge clk);
        checks++; if (cmd_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", cmd_valid); end
        checks++; if (cmd_addr !== 8'h00) begin failures++; $display("FAIL reset_addr got=%02h exp=00", cmd_addr); end
        checks++; if (cmd_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%02h exp=00", cmd_data); end
        checks++; if (cmd_repeat !== 1'b0) begin failures++; $display("FAIL reset_repeat got=%0b exp=0", cmd_repeat); end
        checks++; if (err_count !== 8'd0) begin failures++; $display("FAIL reset_err got=%0d exp=0", err_count); end
        checks++; if (drop_count !== 8'd0) begin failures++; $display("FAIL reset_drop got=%0d exp=0", drop_count); end
        rst = 1'b1;
    endtask

    task automatic test_single();
        cmd_ready = 1'b1;
        send(32'h27D8EF10);
        checks++; if (cmd_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%0b exp=1", cmd_valid); end
        checks++; if (cmd_addr !== 8'h10) begin failures++; $display("FAIL single_addr got=%02h exp=10", cmd_addr); end
        checks++; if (cmd_data !== 8'hD8) begin failures++; $display("FAIL single_data got=%02h exp=d8", cmd_data); end
        checks++; if (cmd_repeat !== 1'b0) begin failures++; $display("FAIL single_repeat got=%0b exp=0", cmd_repeat); end
        @(negedge clk);
        checks++; if (cmd_valid !== 1'b0) begin failures++; $display("FAIL single_drained got=%0b exp=0", cmd_valid); end
    endtask

    task automatic test_repeat();
        // Two cycles after the first frame: well inside the window.
        send(32'h27D8EF10);
        checks++; if (cmd_repeat !== 1'b1 || cmd_valid !== 1'b1) begin failures++; $display("FAIL repeat_near got=%0b/%0b exp=1/1", cmd_valid, cmd_repeat); end
        // Exactly REPEAT_WINDOW-1 cycles later: last eligible arrival.
        repeat (REPEAT_WINDOW - 2) @(negedge clk);
        send(32'h27D8EF10);
        checks++; if (cmd_repeat !== 1'b1 || cmd_valid !== 1'b1) begin failures++; $display("FAIL repeat_edge got=%0b/%0b exp=1/1", cmd_valid, cmd_repeat); end
        // Exactly REPEAT_WINDOW cycles later: window has expired.
        repeat (REPEAT_WINDOW - 1) @(negedge clk);
        send(32'h27D8EF10);
        checks++; if (cmd_repeat !== 1'b0 || cmd_valid !== 1'b1) begin failures++; $display("FAIL repeat_expired got=%0b/%0b exp=1/0", cmd_valid, cmd_repeat); end
        checks++; if (cmd_addr !== 8'h10 || cmd_data !== 8'hD8) begin failures++; $display("FAIL repeat_payload got=%02h/%02h exp=10/d8", cmd_addr, cmd_data); end
    endtask

    task automatic test_errors();
        send(32'h27D8EE10);
        checks++; if (err_count !== 8'd1) begin failures++; $display("FAIL err_first got=%0d exp=1", err_count); end
        checks++; if (cmd_valid !== 1'b0) begin failures++; $display("FAIL err_no_push got=%0b exp=0", cmd_valid); end
        for (int i = 0; i < 254; i++) send(32'h28D8EF10);
        checks++; if (err_count !== 8'd255) begin failures++; $display("FAIL err_reach_max got=%0d exp=255", err_count); end
        for (int i = 0; i < 2; i++) send(32'h27D8EE10);
        checks++; if (err_count !== 8'd255) begin failures++; $display("FAIL err_saturate got=%0d exp=255", err_count); end
        checks++; if (cmd_valid !== 1'b0 || drop_count !== 8'd0) begin failures++; $display("FAIL err_side_effect got=%0b/%0d exp=0/0", cmd_valid, drop_count); end
    endtask

    task automatic test_overflow();
        logic [7:0] exp_addr [4];
        cmd_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(mk(8'h20 + 8'(i), 8'h40 + 8'(i)));
        checks++; if (drop_count !== 8'd1) begin failures++; $display("FAIL ovf_drop got=%0d exp=1", drop_count); end
        checks++; if (cmd_valid !== 1'b1 || cmd_addr !== 8'h20) begin failures++; $display("FAIL ovf_head got=%0b/%02h exp=1/20", cmd_valid, cmd_addr); end
        // Full queue: push and pop together must not drop.
        cmd_ready = 1'b1;
        send(mk(8'h2A, 8'h4A));
        cmd_ready = 1'b0;
        checks++; if (drop_count !== 8'd1) begin failures++; $display("FAIL full_pop_drop got=%0d exp=1", drop_count); end
        checks++; if (cmd_addr !== 8'h21) begin failures++; $display("FAIL full_pop_head got=%02h exp=21", cmd_addr); end
        exp_addr[0] = 8'h21; exp_addr[1] = 8'h22; exp_addr[2] = 8'h23; exp_addr[3] = 8'h2A;
        cmd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            $display("drain idx=%0d valid=%0b addr=%02h data=%02h rep=%0b", i, cmd_valid, cmd_addr, cmd_data, cmd_repeat);
            checks++; if (cmd_valid !== 1'b1 || cmd_addr !== exp_addr[i]) begin failures++; $display("FAIL drain_addr idx=%0d got=%0b/%02h exp=1/%02h", i, cmd_valid, cmd_addr, exp_addr[i]); end
            checks++; if (cmd_data !== exp_addr[i] + 8'h20 || cmd_repeat !== 1'b0) begin failures++; $display("FAIL drain_data idx=%0d got=%02h/%0b exp=%02h/0", i, cmd_data, cmd_repeat, exp_addr[i] + 8'h20); end
            @(negedge clk);
        end
        checks++; if (cmd_valid !== 1'b0) begin failures++; $display("FAIL drain_empty got=%0b exp=0", cmd_valid); end
        cmd_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) send(mk(8'h50 + 8'(i), 8'h60 + 8'(i)));
        checks++; if (cmd_valid !== 1'b1 || cmd_addr !== 8'h50) begin failures++; $display("FAIL mid_queued got=%0b/%02h exp=1/50", cmd_valid, cmd_addr); end
        // Reset in the same cycle as a frame and a pop request: reset wins.
        rst = 1'b0; burst = mk(8'h55, 8'h65); frame_rdy = 1'b1; cmd_ready = 1'b1;
        @(negedge clk);
        rst = 1'b1; frame_rdy = 1'b0; cmd_ready = 1'b0;
        checks++; if (cmd_valid !== 1'b0) begin failures++; $display("FAIL mid_valid got=%0b exp=0", cmd_valid); end
        checks++; if (err_count !== 8'd0 || drop_count !== 8'd0) begin failures++; $display("FAIL mid_counters got=%0d/%0d exp=0/0", err_count, drop_count); end
        send(mk(8'h52, 8'h62));
        checks++; if (cmd_valid !== 1'b1 || cmd_repeat !== 1'b0) begin failures++; $display("FAIL mid_no_repeat got=%0b/%0b exp=1/0", cmd_valid, cmd_repeat); end
        checks++; if (cmd_addr !== 8'h52 || cmd_data !== 8'h62) begin failures++; $display("FAIL mid_payload got=%02h/%02h exp=52/62", cmd_addr, cmd_data); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_repeat();
        test_errors();
        test_overflow();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
